// File: rtl/l1_i_pkg.sv
// Shared address-field geometry, FSM state type and line width for the L1 instruction cache.
package l1_i_pkg;

    localparam int ADDR_WIDTH   = 64;
    localparam int INDEX_WIDTH  = 6;
    localparam int OFFSET_WIDTH = 6;
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int NUM_SETS     = 1 << INDEX_WIDTH;
    localparam int TAG_LSB      = INDEX_WIDTH + OFFSET_WIDTH;
    localparam int LINE_BITS    = 512;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MISS   = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:TAG_LSB];
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return a[TAG_LSB-1:OFFSET_WIDTH];
    endfunction

    function automatic logic [OFFSET_WIDTH-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] a);
        return a[OFFSET_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/l1_i_tag_array.sv
// Tag + valid store: combinational read, one write port, single-cycle clear of every valid bit.
// Latency 0 for reads, 1 edge for writes/clears; no backpressure.
module l1_i_tag_array
    import l1_i_pkg::*;
(
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [INDEX_WIDTH-1:0] rd_index_i,
    output logic                   rd_valid_o,
    output logic [TAG_WIDTH-1:0]   rd_tag_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_WIDTH-1:0] wr_index_i,
    input  logic [TAG_WIDTH-1:0]   wr_tag_i,
    input  logic                   clear_all_i
);

    logic [NUM_SETS-1:0]  valid_q;
    logic [TAG_WIDTH-1:0] tag_q [NUM_SETS];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];

    // Clear wins over a same-cycle write so a flush can never leave a line alive.
    always_ff @(posedge clk) begin
        if (nrst) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

endmodule

// File: rtl/l1_i_controller.sv
// Direct-mapped L1 I-cache control: 0-cycle hit check, miss -> L2 request -> refill -> retry.
// Misses and flushes stall the core; the L2 request is held until the line returns.
module l1_i_controller
    import l1_i_pkg::*;
(
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    read_C_L1,
    input  logic                    flush,
    output logic                    ready_L1_C,
    output logic                    stall,
    output logic                    read_L1_L2,
    output logic [ADDR_WIDTH-1:0]   address_L1_L2,
    input  logic                    ready_L2_L1,
    output logic [INDEX_WIDTH-1:0]  index,
    output logic [OFFSET_WIDTH-1:0] offset,
    output logic                    refill,
    output logic                    update,
    output logic [31:0]             miss_count
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
    logic                    pending_flush_q, pending_flush_d;
    logic [31:0]             miss_count_q, miss_count_d;

    logic                    tag_valid;
    logic [TAG_WIDTH-1:0]    tag_rd;
    logic                    tag_wr_en;
    logic                    clear_all;

    l1_i_tag_array u_tag_array (
        .clk         (clk),
        .nrst        (nrst),
        .rd_index_i  (index),
        .rd_valid_o  (tag_valid),
        .rd_tag_o    (tag_rd),
        .wr_en_i     (tag_wr_en),
        .wr_index_i  (addr_index(miss_addr_q)),
        .wr_tag_i    (addr_tag(miss_addr_q)),
        .clear_all_i (clear_all)
    );

    always_comb begin
        state_d         = state_q;
        miss_addr_d     = miss_addr_q;
        pending_flush_d = pending_flush_q;
        miss_count_d    = miss_count_q;
        ready_L1_C      = 1'b0;
        stall           = 1'b0;
        read_L1_L2      = 1'b0;
        refill          = 1'b0;
        tag_wr_en       = 1'b0;
        clear_all       = 1'b0;
        index           = addr_index(address);
        offset          = addr_offset(address);

        unique case (state_q)
            ST_IDLE: begin
                // A flush deferred from a miss is applied here, after the refill has landed.
                if (flush || pending_flush_q) begin
                    clear_all       = 1'b1;
                    pending_flush_d = 1'b0;
                    stall           = 1'b1;
                end else if (read_C_L1) begin
                    if (tag_valid && (tag_rd == addr_tag(address))) begin
                        ready_L1_C = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        miss_addr_d  = address;
                        miss_count_d = miss_count_q + 32'd1;
                        state_d      = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                index      = addr_index(miss_addr_q);
                offset     = addr_offset(miss_addr_q);
                stall      = 1'b1;
                read_L1_L2 = 1'b1;
                if (flush) begin
                    pending_flush_d = 1'b1;
                end
                if (ready_L2_L1) begin
                    refill    = 1'b1;
                    tag_wr_en = 1'b1;
                    state_d   = ST_REFILL;
                end
            end
            ST_REFILL: begin
                index   = addr_index(miss_addr_q);
                offset  = addr_offset(miss_addr_q);
                stall   = 1'b1;
                state_d = ST_IDLE;
                if (flush) begin
                    pending_flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q         <= ST_IDLE;
            miss_addr_q     <= '0;
            pending_flush_q <= 1'b0;
            miss_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            miss_addr_q     <= miss_addr_d;
            pending_flush_q <= pending_flush_d;
            miss_count_q    <= miss_count_d;
        end
    end

    assign address_L1_L2 = {miss_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign update        = 1'b0;
    assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_l1_i_controller.sv
// Bench for l1_i_controller: directed scenarios plus random fetches against a set-level cache model.
module tb_l1_i_controller;
    import l1_i_pkg::*;

    logic                    clk = 1'b0;
    logic                    nrst = 1'b1;
    logic [ADDR_WIDTH-1:0]   address = '0;
    logic                    read_C_L1 = 1'b0;
    logic                    flush = 1'b0;
    logic                    ready_L1_C;
    logic                    stall;
    logic                    read_L1_L2;
    logic [ADDR_WIDTH-1:0]   address_L1_L2;
    logic                    ready_L2_L1 = 1'b0;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
    logic                    refill;
    logic                    update;
    logic [31:0]             miss_count;

    int checks = 0;
    int failures = 0;

    // Reference model: which line each set holds, and how many misses have happened.
    bit                   m_valid [64];
    logic [51:0]          m_tag   [64];
    logic [31:0]          m_count;

    l1_i_controller dut (
        .clk           (clk),
        .nrst          (nrst),
        .address       (address),
        .read_C_L1     (read_C_L1),
        .flush         (flush),
        .ready_L1_C    (ready_L1_C),
        .stall         (stall),
        .read_L1_L2    (read_L1_L2),
        .address_L1_L2 (address_L1_L2),
        .ready_L2_L1   (ready_L2_L1),
        .index         (index),
        .offset        (offset),
        .refill        (refill),
        .update        (update),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_count = '0;
    endtask

    task automatic do_fetch(input logic [63:0] a, input int dly);
        logic [5:0] idx;
        logic       hit;
        idx = a[11:6];
        address = a;
        read_C_L1 = 1'b1;
        #1;
        hit = m_valid[idx] && (m_tag[idx] == a[63:12]);
        checks++; if (ready_L1_C !== hit) begin failures++; $display("FAIL lookup_ready addr=%h got=%b exp=%b", a, ready_L1_C, hit); end
        checks++; if (stall !== !hit) begin failures++; $display("FAIL lookup_stall addr=%h got=%b exp=%b", a, stall, !hit); end
        checks++; if (index !== idx) begin failures++; $display("FAIL lookup_index addr=%h got=%h exp=%h", a, index, idx); end
        checks++; if (offset !== a[5:0]) begin failures++; $display("FAIL lookup_offset addr=%h got=%h exp=%h", a, offset, a[5:0]); end
        checks++; if (read_L1_L2 !== 1'b0) begin failures++; $display("FAIL lookup_no_l2 addr=%h got=%b exp=0", a, read_L1_L2); end
        checks++; if (update !== 1'b0) begin failures++; $display("FAIL update_zero got=%b exp=0", update); end
        if (!hit) begin
            m_count = m_count + 32'd1;
            tick;
            address = {$urandom, $urandom};
            #1;
            checks++; if (read_L1_L2 !== 1'b1) begin failures++; $display("FAIL miss_req addr=%h got=%b exp=1", a, read_L1_L2); end
            checks++; if (address_L1_L2 !== {a[63:6], 6'b0}) begin failures++; $display("FAIL miss_addr got=%h exp=%h", address_L1_L2, {a[63:6], 6'b0}); end
            checks++; if (miss_count !== m_count) begin failures++; $display("FAIL miss_count got=%0d exp=%0d", miss_count, m_count); end
            checks++; if (stall !== 1'b1 || ready_L1_C !== 1'b0) begin failures++; $display("FAIL miss_stall got=%b/%b exp=1/0", stall, ready_L1_C); end
            checks++; if (index !== idx) begin failures++; $display("FAIL miss_index_latched got=%h exp=%h", index, idx); end
            for (int i = 0; i < dly; i++) begin
                tick;
                #1;
                checks++; if (read_L1_L2 !== 1'b1 || refill !== 1'b0) begin failures++; $display("FAIL miss_wait req=%b refill=%b exp=1/0", read_L1_L2, refill); end
                checks++; if (address_L1_L2 !== {a[63:6], 6'b0}) begin failures++; $display("FAIL miss_wait_addr got=%h exp=%h", address_L1_L2, {a[63:6], 6'b0}); end
            end
            ready_L2_L1 = 1'b1;
            #1;
            checks++; if (refill !== 1'b1) begin failures++; $display("FAIL refill_pulse got=%b exp=1", refill); end
            checks++; if (index !== idx) begin failures++; $display("FAIL refill_index got=%h exp=%h", index, idx); end
            tick;
            ready_L2_L1 = 1'b0;
            address = a;
            #1;
            checks++; if (refill !== 1'b0 || read_L1_L2 !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL refill_cycle refill=%b req=%b stall=%b exp=0/0/1", refill, read_L1_L2, stall); end
            m_valid[idx] = 1'b1;
            m_tag[idx] = a[63:12];
            tick;
            #1;
            checks++; if (ready_L1_C !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL retry_hit addr=%h ready=%b stall=%b exp=1/0", a, ready_L1_C, stall); end
            checks++; if (offset !== a[5:0]) begin failures++; $display("FAIL retry_offset got=%h exp=%h", offset, a[5:0]); end
        end
        tick;
        read_C_L1 = 1'b0;
    endtask

    task automatic test_reset;
        nrst = 1'b1;
        tick;
        tick;
        nrst = 1'b0;
        model_reset();
        #1;
        checks++; if (ready_L1_C !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL reset_outputs ready=%b stall=%b exp=0/0", ready_L1_C, stall); end
        checks++; if (read_L1_L2 !== 1'b0 || refill !== 1'b0) begin failures++; $display("FAIL reset_l2 req=%b refill=%b exp=0/0", read_L1_L2, refill); end
        checks++; if (address_L1_L2 !== 64'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", address_L1_L2); end
        checks++; if (miss_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", miss_count); end
        tick;
    endtask

    task automatic test_first_miss;
        do_fetch(64'h1040, 3);
    endtask

    task automatic test_hit;
        do_fetch(64'h107C, 0);
        checks++; if (miss_count !== 32'd1) begin failures++; $display("FAIL hit_no_count got=%0d exp=1", miss_count); end
    endtask

    task automatic test_conflict;
        do_fetch(64'h2040, 2);
        do_fetch(64'h1040, 1);
        checks++; if (miss_count !== 32'd3) begin failures++; $display("FAIL conflict_count got=%0d exp=3", miss_count); end
    endtask

    task automatic test_flush_idle;
        address = 64'h1040;
        read_C_L1 = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (ready_L1_C !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL flush_idle ready=%b stall=%b exp=0/1", ready_L1_C, stall); end
        tick;
        flush = 1'b0;
        read_C_L1 = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        do_fetch(64'h1040, 0);
    endtask

    task automatic test_flush_during_miss;
        address = 64'h3000;
        read_C_L1 = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fmiss_start stall=%b exp=1", stall); end
        m_count = m_count + 32'd1;
        tick;
        flush = 1'b1;
        #1;
        checks++; if (read_L1_L2 !== 1'b1) begin failures++; $display("FAIL fmiss_req got=%b exp=1", read_L1_L2); end
        tick;
        flush = 1'b0;
        ready_L2_L1 = 1'b1;
        #1;
        checks++; if (refill !== 1'b1) begin failures++; $display("FAIL fmiss_refill got=%b exp=1", refill); end
        tick;
        ready_L2_L1 = 1'b0;
        tick;
        #1;
        checks++; if (ready_L1_C !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL fmiss_clear ready=%b stall=%b exp=0/1", ready_L1_C, stall); end
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        tick;
        #1;
        checks++; if (ready_L1_C !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL fmiss_retry_miss ready=%b stall=%b exp=0/1", ready_L1_C, stall); end
        m_count = m_count + 32'd1;
        tick;
        #1;
        checks++; if (read_L1_L2 !== 1'b1 || miss_count !== m_count) begin failures++; $display("FAIL fmiss_retry_req req=%b count=%0d exp=1/%0d", read_L1_L2, miss_count, m_count); end
        ready_L2_L1 = 1'b1;
        tick;
        ready_L2_L1 = 1'b0;
        tick;
        #1;
        checks++; if (ready_L1_C !== 1'b1) begin failures++; $display("FAIL fmiss_final_hit got=%b exp=1", ready_L1_C); end
        m_valid[0] = 1'b1;
        m_tag[0] = 52'h3;
        tick;
        read_C_L1 = 1'b0;
    endtask

    task automatic test_reset_mid_miss;
        address = 64'h5040;
        read_C_L1 = 1'b1;
        tick;
        #1;
        checks++; if (read_L1_L2 !== 1'b1) begin failures++; $display("FAIL rmiss_req got=%b exp=1", read_L1_L2); end
        read_C_L1 = 1'b0;
        nrst = 1'b1;
        tick;
        nrst = 1'b0;
        model_reset();
        #1;
        checks++; if (read_L1_L2 !== 1'b0 || miss_count !== 32'd0 || stall !== 1'b0) begin failures++; $display("FAIL rmiss_abandon req=%b count=%0d stall=%b exp=0/0/0", read_L1_L2, miss_count, stall); end
        ready_L2_L1 = 1'b1;
        #1;
        checks++; if (refill !== 1'b0) begin failures++; $display("FAIL rmiss_late_l2 refill=%b exp=0", refill); end
        tick;
        ready_L2_L1 = 1'b0;
        do_fetch(64'h5040, 1);
    endtask

    task automatic test_random;
        logic [51:0] pool [4];
        logic [63:0] a;
        pool[0] = 52'h0;
        pool[1] = 52'h1;
        pool[2] = 52'hF_FFFF_FFFF_FFFF;
        pool[3] = 52'h8_0000_0000_0005;
        for (int n = 0; n < 60; n++) begin
            a = {pool[$urandom_range(0, 3)], 6'($urandom_range(0, 7)), 6'($urandom)};
            do_fetch(a, $urandom_range(0, 4));
        end
    endtask

    task automatic test_count_wrap;
        force dut.miss_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.miss_count_q;
        m_count = 32'hFFFF_FFFF;
        do_fetch(64'h0000_7777_0000_0500, 2);
        checks++; if (miss_count !== 32'd0) begin failures++; $display("FAIL count_wrap got=%h exp=0", miss_count); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_miss();
        test_hit();
        test_conflict();
        test_flush_idle();
        test_flush_during_miss();
        test_reset_mid_miss();
        test_random();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_i_controller.md
Name: l1_i_controller

Overview:
Control stage for the direct-mapped L1 instruction cache. It sits directly upstream of the L1 I data array and drives that array's index, offset, refill and update inputs. It holds the tag and valid arrays, performs the hit check on core fetch requests, and sequences line refills from L2 on a miss. The 512-bit L2 line bus goes straight to the data array; this block only qualifies it through refill.

Parameters:
ADDR_WIDTH, 64, fetch address width
INDEX_WIDTH, 6, set index bits (64 sets)
OFFSET_WIDTH, 6, byte offset bits (64-byte lines)
TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (52), stored tag bits

Ports:
clk  input  1  system clock, all state updates on rising edge
nrst  input  1  reset, synchronous, active-high (1 = reset)
address  input  ADDR_WIDTH  core fetch address
read_C_L1  input  1  core fetch request valid
flush  input  1  invalidate all lines (fence.i)
ready_L1_C  output  1  fetch hit this cycle; read_data_L1_C from the data array is valid
stall  output  1  core must hold request (miss or flush in progress)
read_L1_L2  output  1  line request to L2, held until ready_L2_L1
address_L1_L2  output  ADDR_WIDTH  line-aligned miss address (offset bits 0)
ready_L2_L1  input  1  L2 line valid on read_data_L2_L1 this cycle
index  output  INDEX_WIDTH  to data array
offset  output  OFFSET_WIDTH  to data array
refill  output  1  to data array: write 512-bit L2 line at index
update  output  1  to data array; constant 0 (I-cache is never written by the core)
miss_count  output  32  count of misses since reset, wraps at 2^32

Behaviour:
- Reset (nrst=1 at a clock edge): state=IDLE; all valid bits=0; pending_flush=0; miss_count=0; read_L1_L2=0, refill=0, stall=0, ready_L1_C=0, address_L1_L2=0.
- Address fields: tag=address[63:12], index=address[11:6], offset=address[5:0].
- index/offset outputs: in IDLE, combinational from address. In MISS/REFILL, driven from the latched miss address.
- Hit (IDLE, read_C_L1=1, valid[index]=1, tag match, flush=0): ready_L1_C=1 in the same cycle, stall=0. The data array read is combinational, so hit latency is 0 cycles.
- IDLE -> MISS on read_C_L1=1 with no hit and flush=0:
  - latch address into miss_addr; miss_count+1.
  - stall=1 combinationally in that cycle; ready_L1_C=0.
- MISS:
  - read_L1_L2=1 and address_L1_L2={miss_addr[63:6],6'b0}, both stable until ready_L2_L1.
  - stall=1.
  - ready_L2_L1=1 -> refill=1 in that same cycle (data array captures the line at that edge); tag[idx]=miss tag, valid[idx]=1; next state REFILL. read_L1_L2 drops the following cycle.
- REFILL: one cycle, stall=1, refill=0. Next state is IDLE, where the held request re-looks-up and hits. Total miss penalty = L2 wait + 2 cycles.
- Core address changes during MISS/REFILL are ignored; the latched address is used.
- Flush in IDLE: clear all valid bits at that edge; ready_L1_C=0 and stall=1 for that cycle. Flush has priority over a simultaneous request; the request is re-evaluated the next cycle and misses.
- Flush in MISS/REFILL: set pending_flush; the refill still completes. On entering IDLE, clear all valid bits (including the new line) and pending_flush, with stall=1 for that one cycle.
- ready_L2_L1 outside MISS: ignored.
- Reset mid-miss: abandon the miss and drop read_L1_L2. A late ready_L2_L1 is ignored.
- miss_count wraps 0xFFFFFFFF -> 0.

Decomposition:
- Shared package l1_i_pkg: address field widths/positions, the state enum (IDLE, MISS, REFILL), LINE_BITS=512.
- Sub-module l1_i_tag_array: 64 x (valid + 52-bit tag), combinational read, synchronous write, single-cycle clear-all, synchronous reset clearing valid bits.
- The controller FSM instantiates the tag array.

Test Plan:
- Reset then read_C_L1=1, address=0x1040 -> miss: stall=1, read_L1_L2=1, address_L1_L2=0x1040, miss_count=1. ready_L2_L1 after 3 cycles -> refill=1, index=1 for exactly one cycle. Two cycles later ready_L1_C=1, offset=0.
- After that refill, fetch 0x107C -> hit in the same cycle (ready_L1_C=1, offset=0x3C, index=1), no L2 request.
- Fetch 0x2040 (same index 1, different tag) -> miss with address_L1_L2=0x2040. After refill, 0x1040 misses again; miss_count=3.
- Pulse flush during MISS for 0x3000 -> refill completes, then valid is cleared on return to IDLE. The retried 0x3000 misses again.
- Assert nrst during MISS -> read_L1_L2=0 next cycle, miss_count=0. A later ready_L2_L1 produces no refill.
- Hold update observed 0 throughout all scenarios. Force miss_count to 0xFFFFFFFF; the next miss gives 0.
